fpu_addsub_p: RTL

FPU_ADDSUB_P -- requirements
Module: fpu_addsub_p

---
 rtl/fpu_addsub_p.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_addsub_p.sv
// Multi-cycle floating-point adder/subtractor: one state each for align, add,
// normalise and round, round-to-nearest-even, no denormals and no NaN.
module fpu_addsub_p #(
  parameter int unsigned EXP_W = 6,
  parameter int unsigned MAN_W = 25
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op,
  input  logic [1+EXP_W+MAN_W-1:0] op_a,
  input  logic [1+EXP_W+MAN_W-1:0] op_b,
  output logic                     busy,
  output logic                     done,
  output logic [1+EXP_W+MAN_W-1:0] result,
  output logic [3:0]               status
);

  localparam int unsigned W       = 1 + EXP_W + MAN_W;
  localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EXP_MAX = 2 * BIAS + 1;   // all-ones exponent, i.e. infinity
  localparam int unsigned MW      = MAN_W + 4;      // hidden + fraction + guard/round/sticky
  localparam int unsigned EW      = EXP_W + 2;      // two's-complement working exponent
  localparam int unsigned RW      = MAN_W + 2;      // rounded significand plus carry
  localparam int unsigned LZW     = $clog2(MW + 1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t           state_q;
  logic             busy_q, done_q;
  logic [W-1:0]     result_q;
  logic [3:0]       status_q;

  // Operands captured at acceptance; B already carries the op sign flip.
  logic [W-1:0]     a_q, b_q;

  logic [MW-1:0]    big_m_q, sml_m_q;
  logic [EXP_W-1:0] exp_q;
  logic             sgn_q, sub_q, spec_q, spec_ovf_q;
  logic [W-1:0]     spec_res_q;
  logic [MW:0]      sum_q;
  logic [MW-1:0]    man_q;
  logic [EW-1:0]    nexp_q;
  logic             zero_q;

  function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (v[i]) n = LZW'(MW - 1 - i);
    end
    return n;
  endfunction

  // ALIGN: order operands by magnitude and shift the smaller into place
  logic             sa, sb, a_inf, b_inf, a_big;
  logic [EXP_W-1:0] ea, eb, big_e, sml_e, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    ma, mb, big_m_d, sml_m, sml_sh, shift_mask, sml_m_d;
  logic             sgn_d, sub_d, spec_d, spec_ovf_d;
  logic [W-1:0]     spec_res_d;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;

  always_comb begin
    a_inf      = (ea == {EXP_W{1'b1}});
    b_inf      = (eb == {EXP_W{1'b1}});
    ma         = (ea != '0) ? {1'b1, fa, 3'b000} : '0;
    mb         = (eb != '0) ? {1'b1, fb, 3'b000} : '0;
    a_big      = ({ea, fa} >= {eb, fb});
    big_e      = a_big ? ea : eb;
    sml_e      = a_big ? eb : ea;
    big_m_d    = a_big ? ma : mb;
    sml_m      = a_big ? mb : ma;
    sgn_d      = a_big ? sa : sb;
    sub_d      = sa ^ sb;
    diff       = big_e - sml_e;
    shift_mask = (MW'(1) << diff) - MW'(1);
    sml_sh     = sml_m >> diff;
    if (32'(diff) > MAN_W + 3) begin
      sml_m_d = {{(MW-1){1'b0}}, |sml_m};
    end else begin
      sml_m_d = {sml_sh[MW-1:1], sml_sh[0] | (|(sml_m & shift_mask))};
    end
    spec_d     = a_inf | b_inf;
    spec_ovf_d = a_inf & b_inf & (sa ^ sb);
    spec_res_d = {(a_inf ? sa : sb) & ~spec_ovf_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  // ADD: magnitude add or subtract; big_m_q >= sml_m_q by construction
  logic [MW:0] sum_d;
  assign sum_d = sub_q ? ({1'b0, big_m_q} - {1'b0, sml_m_q})
                       : ({1'b0, big_m_q} + {1'b0, sml_m_q});

  // NORM: carry shifts right keeping sticky, otherwise a full left shift by lzc
  logic [LZW-1:0] lz;
  logic [MW-1:0]  man_d;
  logic [EW-1:0]  nexp_d;
  logic           zero_d;

  always_comb begin
    lz     = lzc(sum_q[MW-1:0]);
    man_d  = sum_q[MW-1:0] << lz;
    nexp_d = EW'(exp_q) - EW'(lz);
    if (sum_q[MW]) begin
      man_d  = {sum_q[MW:2], sum_q[1] | sum_q[0]};
      nexp_d = EW'(exp_q) + EW'(1);
    end
    zero_d = (sum_q == '0);
  end

  // ROUND: nearest-even on guard/round/sticky, then range checks and packing
  logic [RW-1:0]    rnd;
  logic [MAN_W-1:0] frac;
  logic [EW-1:0]    rexp;
  logic             inexact, round_up, zero_sign;
  logic [W-1:0]     result_d;
  logic [3:0]       status_d;

  always_comb begin
    inexact   = |man_q[2:0];
    round_up  = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
    rnd       = {1'b0, man_q[MW-1:3]} + RW'(round_up);
    frac      = rnd[MAN_W-1:0];
    rexp      = nexp_q;
    if (rnd[RW-1]) begin
      frac = rnd[MAN_W:1];
      rexp = nexp_q + EW'(1);
    end
    zero_sign = sub_q ? 1'b0 : sgn_q;
    result_d  = {sgn_q, rexp[EXP_W-1:0], frac};
    status_d  = {2'b00, inexact, 1'b0};
    if (spec_q) begin
      result_d = spec_res_q;
      status_d = {spec_ovf_q, 3'b000};
    end else if (zero_q) begin
      result_d = {zero_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      status_d = 4'b0001;
    end else if (nexp_q[EW-1] || nexp_q == '0) begin
      result_d = {sgn_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      status_d = 4'b0111;
    end else if (rexp >= EW'(EXP_MAX)) begin
      result_d = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      status_d = 4'b1010;
    end
  end

  // Sequencer: one state per stage, stage registers load only in their state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      status_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      big_m_q    <= '0;
      sml_m_q    <= '0;
      exp_q      <= '0;
      sgn_q      <= 1'b0;
      sub_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_ovf_q <= 1'b0;
      spec_res_q <= '0;
      sum_q      <= '0;
      man_q      <= '0;
      nexp_q     <= '0;
      zero_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= {op_b[W-1] ^ op, op_b[W-2:0]};
            busy_q  <= 1'b1;
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          big_m_q    <= big_m_d;
          sml_m_q    <= sml_m_d;
          exp_q      <= big_e;
          sgn_q      <= sgn_d;
          sub_q      <= sub_d;
          spec_q     <= spec_d;
          spec_ovf_q <= spec_ovf_d;
          spec_res_q <= spec_res_d;
          state_q    <= S_ADD;
        end
        S_ADD: begin
          sum_q   <= sum_d;
          state_q <= S_NORM;
        end
        S_NORM: begin
          man_q   <= man_d;
          nexp_q  <= nexp_d;
          zero_q  <= zero_d;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          result_q <= result_d;
          status_q <= status_d;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign status = status_q;

endmodule
